// File: rtl/icache_lite_if.sv
// Request/response fetch bus used on both sides of icache_lite.
// The master drives req/addr and receives data with a one-cycle ready pulse.
interface icache_lite_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ready;

  modport master (output req, output addr, input data, input ready);
  modport slave  (input req, input addr, output data, output ready);
endinterface

// File: rtl/icache_lite.sv
// Direct-mapped, one-word-per-line instruction cache between the core fetch port and mem_ctl.
// Macro ICACHE_WR_SNOOP_EN: PSRAM window becomes cacheable and data-bus writes invalidate matching lines.
module icache_lite #(
  parameter int unsigned LINES      = 8,
  parameter logic [31:0] CACHE_BASE = 32'h0000_0000,
  parameter logic [31:0] CACHE_SIZE = 32'h0100_0000,
  parameter logic [31:0] PSRAM_BASE = 32'h0100_0000,
  parameter logic [31:0] PSRAM_SIZE = 32'h0100_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_lite_if.slave         core_bus,
  icache_lite_if.master        mem_bus,
  input  logic [31:0]          dbus_addr_i,
  input  logic                 dbus_we_i,
  input  logic                 flush_i
);

  localparam int unsigned IDX   = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];
  logic [29:0]        miss_addr_q, miss_addr_d;
  logic               cacheable_q, cacheable_d;
  logic               kill_q, kill_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               wr_en;
  logic [IDX-1:0]     wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic [IDX-1:0]     req_idx;
  logic               lookup_hit;

  logic               snoop_sel;
  logic               snoop_tag_hit;
  logic               snoop_kill;
  logic [IDX-1:0]     snoop_idx;

  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (a >= base) && ((a - base) < size);
  endfunction

  function automatic logic is_cacheable(input logic [31:0] a);
`ifdef ICACHE_WR_SNOOP_EN
    return in_window(a, CACHE_BASE, CACHE_SIZE) || in_window(a, PSRAM_BASE, PSRAM_SIZE);
`else
    return in_window(a, CACHE_BASE, CACHE_SIZE);
`endif
  endfunction

  assign req_idx    = core_bus.addr[IDX+1:2];
  assign lookup_hit = is_cacheable(core_bus.addr) && valid_q[req_idx] &&
                      (tag_q[req_idx] == core_bus.addr[31:IDX+2]);

  assign wr_idx = miss_addr_q[IDX-1:0];
  assign wr_tag = miss_addr_q[29:IDX];

`ifdef ICACHE_WR_SNOOP_EN
  assign snoop_sel     = dbus_we_i && is_cacheable(dbus_addr_i);
  assign snoop_idx     = dbus_addr_i[IDX+1:2];
  assign snoop_tag_hit = valid_q[snoop_idx] && (tag_q[snoop_idx] == dbus_addr_i[31:IDX+2]);
  assign snoop_kill    = snoop_sel && (dbus_addr_i[31:2] == miss_addr_q);
`else
  logic unused_snoop;
  assign unused_snoop  = ^{dbus_addr_i, dbus_we_i, PSRAM_BASE, PSRAM_SIZE};
  assign snoop_sel     = 1'b0;
  assign snoop_idx     = '0;
  assign snoop_tag_hit = 1'b0;
  assign snoop_kill    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    cacheable_d = cacheable_q;
    kill_d      = kill_q;
    rdata_d     = rdata_q;
    wr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_bus.req) begin
          // A flush in the lookup cycle forces the miss path so stale code is never returned.
          if (lookup_hit && !flush_i) begin
            state_d = RESP;
            rdata_d = data_q[req_idx];
          end else begin
            state_d     = REFILL;
            miss_addr_d = core_bus.addr[31:2];
            cacheable_d = is_cacheable(core_bus.addr);
            kill_d      = 1'b0;
          end
        end
      end
      REFILL: begin
        if (flush_i || snoop_kill) kill_d = 1'b1;
        if (mem_bus.ready) begin
          state_d = RESP;
          rdata_d = mem_bus.data;
          wr_en   = cacheable_q && !kill_q && !flush_i && !snoop_kill;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Invalidation is applied after allocation so it wins on a same-cycle collision.
    if (wr_en) valid_d[wr_idx] = 1'b1;
    if (flush_i) valid_d = '0;
    if (snoop_sel && (snoop_tag_hit || (wr_en && (snoop_idx == wr_idx))))
      valid_d[snoop_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      cacheable_q <= 1'b0;
      kill_q      <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      cacheable_q <= cacheable_d;
      kill_q      <= kill_d;
      rdata_q     <= rdata_d;
      if (wr_en) begin
        tag_q[wr_idx]  <= wr_tag;
        data_q[wr_idx] <= mem_bus.data;
      end
    end
  end

  assign core_bus.data  = rdata_q;
  assign core_bus.ready = (state_q == RESP);
  assign mem_bus.req    = (state_q == REFILL);
  assign mem_bus.addr   = {miss_addr_q, 2'b00};

endmodule

// File: tb/tb_icache_lite.sv
// Scoreboard bench for icache_lite: a latency-programmable memory model serves refills,
// expected fetch words are queued per request and compared when core ready pulses.
module tb_icache_lite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dbus_addr = '0;
  logic        dbus_we = 1'b0;
  logic        flush = 1'b0;

  icache_lite_if core_bus ();
  icache_lite_if mem_bus ();

  icache_lite dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_bus   (core_bus),
    .mem_bus    (mem_bus),
    .dbus_addr_i(dbus_addr),
    .dbus_we_i  (dbus_we),
    .flush_i    (flush)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mem_lat = 20;
  int mem_cnt = 0;
  int mem_served = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'h1);
  endfunction

  // Memory model: answers a held request after mem_lat+1 cycles with a one-cycle ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_bus.ready <= 1'b0;
      mem_bus.data  <= '0;
      mem_cnt       <= 0;
    end else begin
      mem_bus.ready <= 1'b0;
      if (mem_bus.req && !mem_bus.ready) begin
        if (mem_cnt >= mem_lat) begin
          mem_bus.ready <= 1'b1;
          mem_bus.data  <= word_of(mem_bus.addr);
          mem_cnt       <= 0;
          mem_served    <= mem_served + 1;
          last_addr     <= mem_bus.addr;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else if (!mem_bus.req) begin
        mem_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (core_bus.ready) begin
      if (exp_q.size() == 0) check_val("unexpected ready", 32'd1, 32'd0);
      else check_val("rdata", core_bus.data, exp_q.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] a, input bit miss, input int flush_at, input string tag);
    int cyc;
    int mr_cyc;
    int served0;
    served0 = mem_served;
    exp_q.push_back(word_of({a[31:2], 2'b00}));
    core_bus.req  = 1'b1;
    core_bus.addr = a;
    if (flush_at == 0) flush = 1'b1;
    cyc = 0;
    mr_cyc = -10;
    do begin
      @(negedge clk);
      cyc++;
      if (flush) flush = 1'b0;
      if (cyc == flush_at) flush = 1'b1;
      if (mem_bus.ready) mr_cyc = cyc;
    end while (!core_bus.ready && cyc < 400);
    core_bus.req = 1'b0;
    flush = 1'b0;
    if (!core_bus.ready) begin
      check_val({tag, " timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else if (miss) begin
      check_val({tag, " miss latency"}, cyc, mr_cyc + 1);
    end else begin
      check_val({tag, " hit latency"}, cyc, 32'd1);
    end
    check_val({tag, " mem requests"}, mem_served - served0, miss ? 32'd1 : 32'd0);
    @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic snoop_write(input logic [31:0] a);
    dbus_addr = a;
    dbus_we   = 1'b1;
    @(negedge clk);
    dbus_we   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    core_bus.req  = 1'b0;
    core_bus.addr = '0;
    repeat (3) @(negedge clk);
    check_val("reset ready", {31'd0, core_bus.ready}, 32'd0);
    check_val("reset data", core_bus.data, 32'd0);
    check_val("reset mem req", {31'd0, mem_bus.req}, 32'd0);
    check_val("reset mem addr", mem_bus.addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss with slow memory, then re-fetch hits
    mem_lat = 20;
    fetch(32'h100, 1'b1, -1, "t1 cold");
    check_val("t1 mem addr", last_addr, 32'h100);
    mem_lat = 3;
    fetch(32'h100, 1'b0, -1, "t2 hit");
    fetch(32'h100, 1'b0, -1, "t2 hit again");
    repeat (3) @(negedge clk);
    check_val("data hold", core_bus.data, 32'h13);

    // Conflict on index 0
    fetch(32'h120, 1'b1, -1, "t3 conflict");
    check_val("t3 mem addr", last_addr, 32'h120);
    fetch(32'h100, 1'b1, -1, "t3 refetch");
    fetch(32'h103, 1'b0, -1, "t3 byte offset hit");

    // Flush handling
    pulse_flush();
    fetch(32'h100, 1'b1, -1, "t4 after flush");
    fetch(32'h104, 1'b1, 3, "t4 flush in refill");
    fetch(32'h104, 1'b1, -1, "t4 not allocated");
    fetch(32'h104, 1'b0, -1, "t4 now cached");
    fetch(32'h100, 1'b1, 0, "t4 flush with lookup");
    fetch(32'h100, 1'b0, -1, "t4 reallocated");

    // Uncached pass-through
    fetch(32'h4000_0000, 1'b1, -1, "t5 uncached a");
    fetch(32'h4000_0000, 1'b1, -1, "t5 uncached b");
    check_val("t5 mem addr", last_addr, 32'h4000_0000);
    fetch(32'h100, 1'b0, -1, "t5 cached survives");

`ifdef ICACHE_WR_SNOOP_EN
    fetch(32'h0100_0010, 1'b1, -1, "t6 psram fill");
    fetch(32'h0100_0010, 1'b0, -1, "t6 psram hit");
    snoop_write(32'h0100_0014);
    fetch(32'h0100_0010, 1'b0, -1, "t6 other word kept");
    snoop_write(32'h0100_0010);
    fetch(32'h0100_0010, 1'b1, -1, "t6 snooped out");
`else
    snoop_write(32'h0100_0010);
    fetch(32'h0100_0010, 1'b1, -1, "t6 psram a");
    fetch(32'h0100_0010, 1'b1, -1, "t6 psram b");
`endif

    // Reset in the middle of a refill
    mem_lat = 20;
    core_bus.req  = 1'b1;
    core_bus.addr = 32'h108;
    repeat (4) @(negedge clk);
    check_val("t7 refill pending", {31'd0, mem_bus.req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_val("t7 req drops", {31'd0, mem_bus.req}, 32'd0);
    core_bus.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("t7 idle mem req", {31'd0, mem_bus.req}, 32'd0);
    check_val("t7 idle ready", {31'd0, core_bus.ready}, 32'd0);
    mem_lat = 3;
    fetch(32'h100, 1'b1, -1, "t7 cleared");
    fetch(32'h100, 1'b0, -1, "t7 hit");

    check_val("scoreboard empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
